lockin_frame_demod: RTL and testbench

LOCKIN_FRAME_DEMOD -- requirements
Module: lockin_frame_demod

---
 rtl/lockin_pkg.sv | 25 ++
 rtl/lockin_ref_table.sv | 36 +++
 rtl/lockin_frame_demod.sv | 168 ++++++++++++++++
 tb/tb_lockin_frame_demod.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockin_pkg.sv
// Shared datapath widths, FSM encoding and helpers for the lock-in frame demodulator.
// Combinational definitions only; no clocked logic lives here.
package lockin_pkg;

    localparam int DATA_W = 32;
    localparam int PROD_W = 48;
    localparam int ACC_W  = 64;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Stage-1 capture of an accepted sample and its frame position flags.
    typedef struct packed {
        logic                     first;
        logic                     last;
        logic signed [DATA_W-1:0] dat;
    } smp_t;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/lockin_ref_table.sv
// Sin/cos reference table: simple dual-port RAM, one write port, one read port.
// Latency: 1-cycle registered read; same-address read during write returns old data.
// Backpressure: none; reads and writes are accepted every cycle.
module lockin_ref_table #(
    parameter int DEPTH  = 1024,
    parameter int W      = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic signed [W-1:0] wr_sin,
    input  logic signed [W-1:0] wr_cos,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic signed [W-1:0] rd_sin,
    output logic signed [W-1:0] rd_cos
);

    logic [2*W-1:0] mem [DEPTH];
    logic [2*W-1:0] rd_q;

    // No reset: table contents survive reset and are owned by software.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_sin, wr_cos};
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

    assign rd_sin = rd_q[2*W-1:W];
    assign rd_cos = rd_q[W-1:0];

endmodule

// File: rtl/lockin_frame_demod.sv
// Frame-synchronous lock-in demodulator: correlates M-sample frames against sin/cos tables.
// Latency: out_valid 3 cycles after the edge accepting the last sample of a frame.
// Backpressure: none; samples are consumed or ignored on the cycle they are presented.
module lockin_frame_demod
    import lockin_pkg::*;
#(
    parameter int REF_DEPTH = 1024,
    parameter int REF_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [15:0]                  ptos_x_ciclo,
    input  logic                         data_in_valid,
    input  logic signed [DATA_W-1:0]     data_in,
    input  logic                         sync_in,
    input  logic                         ref_wr_en,
    input  logic [$clog2(REF_DEPTH)-1:0] ref_wr_addr,
    input  logic signed [REF_W-1:0]      ref_wr_sin,
    input  logic signed [REF_W-1:0]      ref_wr_cos,
    output logic signed [ACC_W-1:0]      x_out,
    output logic signed [ACC_W-1:0]      y_out,
    output logic                         out_valid,
    output logic [15:0]                  frames_done,
    output logic [15:0]                  frames_aborted,
    output logic                         cfg_error
);

    localparam int          ADDR_W    = $clog2(REF_DEPTH);
    localparam logic [16:0] DEPTH_W17 = 17'(REF_DEPTH);

    state_t      state, state_nxt;
    logic [15:0] idx, idx_nxt;
    logic [15:0] cur_k;
    logic        accept;
    logic        sample_last;
    logic        abort;

    logic                    s1_vld;
    smp_t                    s1;
    logic signed [REF_W-1:0] rd_sin, rd_cos;

    logic                     s2_vld, s2_first, s2_last;
    logic signed [PROD_W-1:0] p_sin, p_cos;

    logic                    launch;
    logic signed [ACC_W-1:0] acc_x, acc_y;

    assign cfg_error = (ptos_x_ciclo == 16'd0) || ({1'b0, ptos_x_ciclo} > DEPTH_W17);

    // A sync sample always restarts at index 0, whether from IDLE or as an abort.
    always_comb begin
        cur_k       = sync_in ? 16'd0 : idx;
        accept      = enable && data_in_valid && !cfg_error && (sync_in || (state == ST_ACCUM));
        sample_last = (cur_k == (ptos_x_ciclo - 16'd1));
        abort       = accept && sync_in && (state == ST_ACCUM);
        state_nxt   = state;
        idx_nxt     = idx;
        if (cfg_error) begin
            state_nxt = ST_IDLE;
            idx_nxt   = 16'd0;
        end else if (accept) begin
            if (sample_last) begin
                state_nxt = ST_IDLE;
                idx_nxt   = 16'd0;
            end else begin
                state_nxt = ST_ACCUM;
                idx_nxt   = (cur_k == 16'hFFFF) ? cur_k : cur_k + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            idx            <= 16'd0;
            frames_aborted <= 16'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (abort && (frames_aborted != 16'hFFFF)) begin
                frames_aborted <= frames_aborted + 16'd1;
            end
        end
    end

    lockin_ref_table #(
        .DEPTH  (REF_DEPTH),
        .W      (REF_W),
        .ADDR_W (ADDR_W)
    ) u_ref_table (
        .clk     (clk),
        .wr_en   (ref_wr_en),
        .wr_addr (ref_wr_addr),
        .wr_sin  (ref_wr_sin),
        .wr_cos  (ref_wr_cos),
        .rd_en   (accept),
        .rd_addr (cur_k[ADDR_W-1:0]),
        .rd_sin  (rd_sin),
        .rd_cos  (rd_cos)
    );

    // Stage 1: sample capture alongside the table read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_vld <= 1'b0;
            s1     <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1.first <= sync_in;
                s1.last  <= sample_last;
                s1.dat   <= data_in;
            end
        end
    end

    // Stage 2: multiply.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_vld   <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            p_sin    <= '0;
            p_cos    <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_first <= s1.first;
                s2_last  <= s1.last;
                p_sin    <= PROD_W'($signed(s1.dat)) * PROD_W'(rd_sin);
                p_cos    <= PROD_W'($signed(s1.dat)) * PROD_W'(rd_cos);
            end
        end
    end

    // Stage 3: accumulate; the first sample of a frame loads rather than adds.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_x  <= '0;
            acc_y  <= '0;
            launch <= 1'b0;
        end else begin
            launch <= s2_vld && s2_last;
            if (s2_vld) begin
                acc_x <= s2_first ? sext_prod(p_sin) : acc_x + sext_prod(p_sin);
                acc_y <= s2_first ? sext_prod(p_cos) : acc_y + sext_prod(p_cos);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            frames_done <= 16'd0;
        end else begin
            out_valid <= launch;
            if (launch) begin
                x_out       <= acc_x;
                y_out       <= acc_y;
                frames_done <= frames_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lockin_frame_demod.sv
// Bench for lockin_frame_demod: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a frame-level reference model.
module tb_lockin_frame_demod;

    localparam int DEPTH = 1024;

    logic               clk = 1'b0;
    logic               reset_n, enable, data_in_valid, sync_in, ref_wr_en;
    logic [15:0]        ptos_x_ciclo;
    logic signed [31:0] data_in;
    logic [9:0]         ref_wr_addr;
    logic signed [15:0] ref_wr_sin, ref_wr_cos;
    logic signed [63:0] x_out, y_out;
    logic               out_valid, cfg_error;
    logic [15:0]        frames_done, frames_aborted;

    always #5 clk = ~clk;

    lockin_frame_demod #(.REF_DEPTH(DEPTH), .REF_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .ptos_x_ciclo   (ptos_x_ciclo),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .sync_in        (sync_in),
        .ref_wr_en      (ref_wr_en),
        .ref_wr_addr    (ref_wr_addr),
        .ref_wr_sin     (ref_wr_sin),
        .ref_wr_cos     (ref_wr_cos),
        .x_out          (x_out),
        .y_out          (y_out),
        .out_valid      (out_valid),
        .frames_done    (frames_done),
        .frames_aborted (frames_aborted),
        .cfg_error      (cfg_error)
    );

    typedef struct packed {
        int               tab;
        int               m;
        int               n;
        logic [0:7][31:0] d;
        logic [0:7]       s;
        longint           ex;
        longint           ey;
        int               nout;
        int               nab;
    } vec_t;

    typedef struct {
        int     e;
        longint x;
        longint y;
    } res_t;

    int      n_vec = 0;
    int      n_miss = 0;
    int      edge_n = 0;
    shortint sin_m [DEPTH];
    shortint cos_m [DEPTH];
    res_t    obs_q [$];
    res_t    exp_q [$];
    int      frame_d [$];
    bit      in_frame = 1'b0;
    int      exp_ab = 0;
    vec_t    vecs [7];

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        #1;
        if (out_valid === 1'b1) obs_q.push_back('{edge_n, x_out, y_out});
    end

    function automatic vec_t mk(input int tab, input int m, input int n, input logic [0:7][31:0] d,
                                input logic [0:7] s, input longint ex, input longint ey,
                                input int nout, input int nab);
        vec_t v;
        v.tab = tab; v.m = m; v.n = n; v.d = d; v.s = s;
        v.ex = ex; v.ey = ey; v.nout = nout; v.nab = nab;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic wr_ref(input int a, input int s, input int c);
        ref_wr_en   = 1'b1;
        ref_wr_addr = 10'(a);
        ref_wr_sin  = 16'(s);
        ref_wr_cos  = 16'(c);
        sin_m[a]    = shortint'(s);
        cos_m[a]    = shortint'(c);
        tick();
        ref_wr_en   = 1'b0;
    endtask

    task automatic load_tab(input int kind);
        int qs [4] = '{0, 1, 0, -1};
        int qc [4] = '{1, 0, -1, 0};
        for (int i = 0; i < 4; i++) begin
            if (kind == 0) wr_ref(i, 1, 0);
            else           wr_ref(i, qs[i], qc[i]);
        end
    endtask

    task automatic send(input int d, input bit s, output int e);
        data_in_valid = 1'b1;
        data_in       = d;
        sync_in       = s;
        tick();
        e             = edge_n;
        data_in_valid = 1'b0;
        sync_in       = 1'b0;
    endtask

    task automatic settle();
        repeat (6) tick();
    endtask

    // Frame-level model: a frame is the run of accepted samples from a sync until M are seen.
    task automatic model_acc(input int d, input bit s, input int e);
        longint sx, sy;
        if (s) begin
            if (in_frame) exp_ab++;
            frame_d.delete();
            in_frame = 1'b1;
        end
        if (in_frame) begin
            frame_d.push_back(d);
            if (frame_d.size() == int'(ptos_x_ciclo)) begin
                sx = 0;
                sy = 0;
                foreach (frame_d[k]) begin
                    sx += longint'(frame_d[k]) * longint'(sin_m[k]);
                    sy += longint'(frame_d[k]) * longint'(cos_m[k]);
                end
                exp_q.push_back('{e + 3, sx, sy});
                in_frame = 1'b0;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        logic [15:0] ab0, fd0;
        int          e_last;
        enable = 1'b0;
        load_tab(v.tab);
        ptos_x_ciclo = 16'(v.m);
        enable = 1'b1;
        obs_q.delete();
        ab0 = frames_aborted;
        fd0 = frames_done;
        e_last = 0;
        for (int i = 0; i < v.n; i++) send(int'(v.d[i]), v.s[i], e_last);
        settle();
        chk($sformatf("v%0d_nout", vi), obs_q.size(), v.nout);
        if (obs_q.size() > 0 && v.nout > 0) begin
            chk($sformatf("v%0d_x", vi), obs_q[0].x, v.ex);
            chk($sformatf("v%0d_y", vi), obs_q[0].y, v.ey);
            chk($sformatf("v%0d_lat", vi), obs_q[0].e - e_last, 3);
        end
        chk($sformatf("v%0d_aborted", vi), 16'(frames_aborted - ab0), v.nab);
        chk($sformatf("v%0d_done", vi), 16'(frames_done - fd0), v.nout);
    endtask

    initial begin
        int          e;
        int          dmin;
        logic [15:0] ab0, fd0;
        bit          rv, rs, ren;
        int          rd;

        vecs[0] = mk(0, 4, 4, {32'sd1, 32'sd2, 32'sd3, 32'sd4, 128'd0}, 8'b1000_0000, 10, 0, 1, 0);
        vecs[1] = mk(1, 4, 4, {32'sd1000, 32'sd0, -32'sd1000, 32'sd0, 128'd0}, 8'b1000_0000, 0, 2000, 1, 0);
        vecs[2] = mk(0, 4, 6, {32'sd5, 32'sd6, 32'sd7, 32'sd8, 32'sd9, 32'sd10, 64'd0}, 8'b1010_0000, 34, 0, 1, 1);
        vecs[3] = mk(1, 1, 1, {32'sd7, 224'd0}, 8'b1000_0000, 0, 7, 1, 0);
        vecs[4] = mk(0, 4, 3, {32'sd1, 32'sd2, 32'sd3, 160'd0}, 8'b0000_0000, 0, 0, 0, 0);
        vecs[5] = mk(1, 2, 2, {32'sd3, 32'sd4, 192'd0}, 8'b1000_0000, 4, 3, 1, 0);
        vecs[6] = mk(1, 4, 4, {32'sd1, 32'sd2, 32'sd3, 32'sd4, 128'd0}, 8'b1111_0000, 0, 0, 0, 3);

        reset_n = 1'b0; enable = 1'b0; ptos_x_ciclo = 16'd4;
        data_in_valid = 1'b0; data_in = '0; sync_in = 1'b0;
        ref_wr_en = 1'b0; ref_wr_addr = '0; ref_wr_sin = '0; ref_wr_cos = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", frames_done, 0);
        chk("rst_aborted", frames_aborted, 0);
        chk("rst_cfg_error", cfg_error, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset at index 2 of an M=4 frame, then a clean frame.
        ptos_x_ciclo = 16'd4;
        enable = 1'b1;
        obs_q.delete();
        send(1, 1'b1, e);
        send(2, 1'b0, e);
        reset_n = 1'b0;
        send(3, 1'b0, e);
        reset_n = 1'b1;
        settle();
        chk("rstmid_nout", obs_q.size(), 0);
        chk("rstmid_done", frames_done, 0);
        chk("rstmid_aborted", frames_aborted, 0);
        chk("rstmid_x", x_out, 0);
        send(10, 1'b1, e);
        send(20, 1'b0, e);
        send(30, 1'b0, e);
        send(40, 1'b0, e);
        settle();
        chk("rstmid_next_nout", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            chk("rstmid_next_x", obs_q[0].x, -20);
            chk("rstmid_next_y", obs_q[0].y, -20);
            chk("rstmid_next_lat", obs_q[0].e - e, 3);
        end
        chk("rstmid_next_done", frames_done, 1);

        // Enable low mid-frame ignores samples; dropping enable right after the last still completes.
        obs_q.delete();
        send(1, 1'b1, e);
        send(2, 1'b0, e);
        enable = 1'b0;
        send(100, 1'b0, e);
        send(200, 1'b1, e);
        enable = 1'b1;
        send(3, 1'b0, e);
        send(4, 1'b0, e);
        enable = 1'b0;
        settle();
        chk("en_nout", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            chk("en_x", obs_q[0].x, -2);
            chk("en_y", obs_q[0].y, -2);
            chk("en_lat", obs_q[0].e - e, 3);
        end
        enable = 1'b1;

        // Illegal M blocks acceptance; a legal M resumes normal framing.
        obs_q.delete();
        ptos_x_ciclo = 16'd0;
        tick();
        chk("cfg_m0", cfg_error, 1);
        send(5, 1'b1, e);
        send(5, 1'b1, e);
        send(5, 1'b1, e);
        settle();
        chk("cfg_m0_nout", obs_q.size(), 0);
        ptos_x_ciclo = 16'd1025;
        tick();
        chk("cfg_m1025", cfg_error, 1);
        ptos_x_ciclo = 16'd1024;
        tick();
        chk("cfg_m1024", cfg_error, 0);
        ptos_x_ciclo = 16'd2;
        tick();
        chk("cfg_m2", cfg_error, 0);
        send(5, 1'b1, e);
        send(6, 1'b0, e);
        settle();
        chk("cfg_m2_nout", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            chk("cfg_m2_x", obs_q[0].x, 6);
            chk("cfg_m2_y", obs_q[0].y, 5);
        end

        // Full-scale corner: 1024 x (-2^31 * -2^15) must reach exactly 2^56.
        enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) wr_ref(i, -32768, 0);
        ptos_x_ciclo = 16'd1024;
        enable = 1'b1;
        obs_q.delete();
        dmin = int'(32'h8000_0000);
        send(dmin, 1'b1, e);
        for (int i = 1; i < DEPTH; i++) send(dmin, 1'b0, e);
        settle();
        chk("big_nout", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            chk("big_x", obs_q[0].x, 64'sh0100_0000_0000_0000);
            chk("big_y", obs_q[0].y, 0);
        end

        // Randomized traffic against the frame-level model.
        enable = 1'b0;
        for (int i = 0; i < 16; i++)
            wr_ref(i, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        obs_q.delete();
        exp_q.delete();
        in_frame = 1'b0;
        exp_ab = 0;
        ab0 = frames_aborted;
        fd0 = frames_done;
        for (int r = 0; r < 8; r++) begin
            ptos_x_ciclo = 16'($urandom_range(1, 12));
            for (int c = 0; c < 80; c++) begin
                rv  = ($urandom_range(0, 3) != 0);
                rs  = ($urandom_range(0, 6) == 0);
                ren = ($urandom_range(0, 9) != 0);
                rd  = int'($urandom);
                enable        = ren;
                data_in_valid = rv;
                data_in       = rd;
                sync_in       = rs;
                tick();
                if (rv && ren) model_acc(rd, rs, edge_n);
            end
        end
        enable = 1'b1;
        data_in_valid = 1'b0;
        sync_in = 1'b0;
        settle();
        chk("rand_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("rand%0d_x", i), obs_q[i].x, exp_q[i].x);
            chk($sformatf("rand%0d_y", i), obs_q[i].y, exp_q[i].y);
            chk($sformatf("rand%0d_edge", i), obs_q[i].e, exp_q[i].e);
        end
        chk("rand_aborted", 16'(frames_aborted - ab0), exp_ab);
        chk("rand_done", 16'(frames_done - fd0), exp_q.size());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
